// File: rtl/sata_link_txrx_sched_if.sv
// Primitive type package and scheduler bus interface for sata_link_txrx_sched.
// The scheduler connects to the slave modport; ingress/decode and the wrmod/rdmod pair sit on master.
package sata_link_txrx_sched_pkg;

  typedef enum logic [3:0] {
    P_SYNC  = 4'd0,
    P_X_RDY = 4'd1,
    P_R_RDY = 4'd2,
    P_R_IP  = 4'd3,
    P_R_OK  = 4'd4,
    P_R_ERR = 4'd5,
    P_SOF   = 4'd6,
    P_EOF   = 4'd7,
    P_WTRM  = 4'd8,
    P_HOLD  = 4'd9,
    P_HOLDA = 4'd10,
    P_CONT  = 4'd11,
    P_ALIGN = 4'd12,
    P_DATA  = 4'd13
  } sata_p_t;

endpackage

interface sata_link_txrx_sched_if;
  import sata_link_txrx_sched_pkg::*;

  logic        phyrdy;
  sata_p_t     rx_dat_type;
  logic        roll_insert;
  logic        tx_req;
  logic        wr_cpl;
  logic        wr_no_busy;
  logic        rd_cpl;
  logic        wr_req;
  logic        rd_req;
  logic [2:0]  sched_state;
  logic        wdt_err;
  logic [15:0] stat_tx_cnt;
  logic [15:0] stat_rx_cnt;
  logic [15:0] stat_coll_cnt;

  modport master (
    output phyrdy, rx_dat_type, roll_insert, tx_req, wr_cpl, wr_no_busy, rd_cpl,
    input  wr_req, rd_req, sched_state, wdt_err, stat_tx_cnt, stat_rx_cnt, stat_coll_cnt
  );

  modport slave (
    input  phyrdy, rx_dat_type, roll_insert, tx_req, wr_cpl, wr_no_busy, rd_cpl,
    output wr_req, rd_req, sched_state, wdt_err, stat_tx_cnt, stat_rx_cnt, stat_coll_cnt
  );

endinterface

// File: rtl/sata_link_txrx_sched.sv
// Link-layer TX/RX ownership scheduler with X_RDY collision arbitration, SYNC gap and watchdog.
// Define SATA_LINK_SCHED_STAT_EN to build the frame/collision statistics counters.
module sata_link_txrx_sched
  import sata_link_txrx_sched_pkg::*;
#(
  parameter bit               ROLE    = 1'b1,
  parameter int               GAP_CYC = 4,
  parameter int               WDT_W   = 16,
  parameter logic [WDT_W-1:0] WDT_MAX = {WDT_W{1'b1}}
) (
  input logic                   clk,
  input logic                   rst_n,
  sata_link_txrx_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_NOCOMM = 3'd0,
    S_IDLE   = 3'd1,
    S_WR     = 3'd2,
    S_RD     = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_MAX - 1'b1;

  state_t           state;
  state_t           nxt;
  logic [WDT_W-1:0] wdt_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             wr_req_q;
  logic             rd_req_q;
  logic             wdt_err_q;
  logic             wdt_fire;
  logic             x_rdy;

  assign x_rdy = (bus.rx_dat_type == P_X_RDY);

  // Decision for the next cycle; phyrdy loss overrides everything, cpl beats a watchdog expiry.
  always_comb begin
    nxt      = state;
    wdt_fire = 1'b0;
    if (!bus.phyrdy) begin
      nxt = S_NOCOMM;
    end else begin
      case (state)
        S_NOCOMM: nxt = S_IDLE;
        S_IDLE: begin
          if (!bus.roll_insert) begin
            if (x_rdy && bus.tx_req) begin
              nxt = (ROLE == 1'b1) ? S_RD : S_WR;
            end else if (x_rdy) begin
              nxt = S_RD;
            end else if (bus.tx_req) begin
              nxt = S_WR;
            end
          end
        end
        S_WR: begin
          if (bus.wr_cpl) begin
            nxt = S_GAP;
          end else if ((ROLE == 1'b1) && bus.wr_no_busy && x_rdy) begin
            nxt = S_RD;
          end else if (wdt_cnt == WDT_LAST) begin
            nxt      = S_GAP;
            wdt_fire = 1'b1;
          end
        end
        S_RD: begin
          if (bus.rd_cpl) begin
            nxt = S_GAP;
          end else if (wdt_cnt == WDT_LAST) begin
            nxt      = S_GAP;
            wdt_fire = 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            nxt = S_IDLE;
          end
        end
        default: nxt = S_NOCOMM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_NOCOMM;
      wdt_cnt   <= '0;
      gap_cnt   <= '0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wdt_err_q <= 1'b0;
    end else begin
      state     <= nxt;
      wr_req_q  <= (nxt == S_WR);
      rd_req_q  <= (nxt == S_RD);
      wdt_err_q <= wdt_fire;
      // Watchdog restarts on every grant, including the WR -> RD handover.
      if ((nxt != state) || !((nxt == S_WR) || (nxt == S_RD))) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
      if ((state == S_GAP) && (nxt == S_GAP)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign bus.wr_req      = wr_req_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.wdt_err     = wdt_err_q;
  assign bus.sched_state = state;

`ifdef SATA_LINK_SCHED_STAT_EN
  logic [15:0] stat_tx_q;
  logic [15:0] stat_rx_q;
  logic [15:0] stat_coll_q;
  logic        tx_hit;
  logic        rx_hit;
  logic        coll_hit;

  // Grants are recognised as state entries; phyrdy loss never enters WR/RD so counts freeze.
  assign tx_hit   = (nxt == S_WR) && (state != S_WR);
  assign rx_hit   = (nxt == S_RD) && (state != S_RD);
  assign coll_hit = ((state == S_IDLE) && bus.phyrdy && !bus.roll_insert && x_rdy && bus.tx_req)
                  || ((state == S_WR) && (nxt == S_RD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_tx_q   <= 16'h0;
      stat_rx_q   <= 16'h0;
      stat_coll_q <= 16'h0;
    end else begin
      if (tx_hit)   stat_tx_q   <= stat_tx_q + 16'd1;
      if (rx_hit)   stat_rx_q   <= stat_rx_q + 16'd1;
      if (coll_hit) stat_coll_q <= stat_coll_q + 16'd1;
    end
  end

  assign bus.stat_tx_cnt   = stat_tx_q;
  assign bus.stat_rx_cnt   = stat_rx_q;
  assign bus.stat_coll_cnt = stat_coll_q;
`else
  assign bus.stat_tx_cnt   = 16'h0;
  assign bus.stat_rx_cnt   = 16'h0;
  assign bus.stat_coll_cnt = 16'h0;
`endif

  a_grant_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(wr_req_q && rd_req_q));

endmodule
